// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the 16-bit CPU blocks (pc, decoder, call_stack).
//   AW     - architectural address width
//   word_t - one address / program-counter value
package cpu_pkg;

    localparam int AW = 16;

    typedef logic [AW-1:0] word_t;

endpackage : cpu_pkg

// File: rtl/call_stack_mem.sv
// call_stack_mem: DEPTH x AW register file holding return addresses.
// Ports:
//   clk   - clock; writes happen on the rising edge
//   we    - write enable
//   waddr - write slot index
//   wdata - word to store
//   raddr - read slot index (asynchronous read)
//   rdata - contents of slot raddr
// Contents are deliberately not reset; the stack pointer alone decides
// which entries are meaningful.
module call_stack_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = cpu_pkg::AW,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [AW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [AW-1:0] rdata
);

    logic [AW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : call_stack_mem

// File: rtl/call_stack.sv
// call_stack: hardware return-address stack feeding the pc load port.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   call     - push pc_in+1 and jump to tgt
//   ret      - pop and jump to the popped address
//   pc_in    - address of the call instruction (pc.out)
//   tgt      - call target address
//   addr, ld - registered load address / one-cycle load strobe to pc
//   depth    - number of valid entries
//   empty    - depth == 0
//   full     - depth == DEPTH
//   err      - sticky fault (overflow, underflow, or call+ret together)
//
// Load handshake: ld is a single-cycle strobe with no back-pressure. When
// ld is high, addr is valid and pc must load it in that same cycle. ld
// only rises for a request accepted at the previous edge; rejected or
// idle cycles leave ld low and addr holding its last value.
module call_stack
    import cpu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = cpu_pkg::AW,
    localparam int SPW  = $clog2(DEPTH) + 1,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           call,
    input  logic           ret,
    input  logic [AW-1:0]  pc_in,
    input  logic [AW-1:0]  tgt,
    output logic [AW-1:0]  addr,
    output logic           ld,
    output logic [SPW-1:0] depth,
    output logic           empty,
    output logic           full,
    output logic           err
);

    logic [SPW-1:0] sp_q, sp_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           ld_q, ld_d;
    logic           err_q, err_d;

    logic           is_empty, is_full;
    logic           call_ok, ret_ok, fault;
    logic           mem_we;
    logic [IW-1:0]  mem_waddr, mem_raddr;
    logic [AW-1:0]  mem_wdata, mem_rdata;

    // Flags come straight from the sp register, so they reflect the
    // operation accepted at the previous edge with no input-to-output path.
    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == SPW'(DEPTH));

    assign call_ok = call & ~ret & ~is_full;
    assign ret_ok  = ret & ~call & ~is_empty;
    assign fault   = (call & ret) | (call & ~ret & is_full) | (ret & ~call & is_empty);

    // sp points at the next free slot; the top entry lives at sp-1.
    // Index truncation is safe: writes only happen when sp < DEPTH and
    // reads are only used when sp >= 1.
    assign mem_we    = call_ok & ~rst;
    assign mem_waddr = sp_q[IW-1:0];
    assign mem_wdata = pc_in + AW'(1);
    assign mem_raddr = IW'(sp_q - SPW'(1));

    call_stack_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    always_comb begin
        sp_d   = sp_q;
        addr_d = addr_q;
        ld_d   = 1'b0;
        err_d  = err_q | fault;
        if (call_ok) begin
            sp_d   = sp_q + SPW'(1);
            addr_d = tgt;
            ld_d   = 1'b1;
        end else if (ret_ok) begin
            sp_d   = sp_q - SPW'(1);
            addr_d = mem_rdata;
            ld_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q   <= '0;
            addr_q <= '0;
            ld_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sp_q   <= sp_d;
            addr_q <= addr_d;
            ld_q   <= ld_d;
            err_q  <= err_d;
        end
    end

    assign addr  = addr_q;
    assign ld    = ld_q;
    assign depth = sp_q;
    assign empty = is_empty;
    assign full  = is_full;
    assign err   = err_q;

endmodule : call_stack

// File: tb/tb_call_stack.sv
// tb_call_stack: directed scoreboard bench for call_stack (DEPTH=16, AW=16).
// Each driven cycle pushes the expected post-edge output vector; a monitor
// pops and compares it #1 after the following rising edge.
module tb_call_stack;

    localparam int DEPTH = 16;
    localparam int AW    = 16;
    localparam int SPW   = 5;
    // {ld, err, full, empty, depth[4:0], addr[15:0]}
    localparam int W     = 4 + SPW + AW;

    logic           clk;
    logic           rst;
    logic           call;
    logic           ret;
    logic [AW-1:0]  pc_in;
    logic [AW-1:0]  tgt;
    logic [AW-1:0]  addr;
    logic           ld;
    logic [SPW-1:0] depth;
    logic           empty;
    logic           full;
    logic           err;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    call_stack #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .call  (call),
        .ret   (ret),
        .pc_in (pc_in),
        .tgt   (tgt),
        .addr  (addr),
        .ld    (ld),
        .depth (depth),
        .empty (empty),
        .full  (full),
        .err   (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst   = 1'b1;
        call  = 1'b0;
        ret   = 1'b0;
        pc_in = '0;
        tgt   = '0;
    end

    // ---------------- helpers / driver ----------------
    function automatic logic [W-1:0] mk(input logic e_ld, input logic e_err,
                                        input logic e_full, input logic e_empty,
                                        input logic [SPW-1:0] e_depth,
                                        input logic [AW-1:0] e_addr);
        return {e_ld, e_err, e_full, e_empty, e_depth, e_addr};
    endfunction

    task automatic drive(input logic d_rst, input logic d_call, input logic d_ret,
                         input logic [AW-1:0] d_pc, input logic [AW-1:0] d_tgt,
                         input logic [W-1:0] e, input string nm);
        @(negedge clk);
        rst   = d_rst;
        call  = d_call;
        ret   = d_ret;
        pc_in = d_pc;
        tgt   = d_tgt;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle(input logic [W-1:0] e, input string nm);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, e, nm);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] e;
        logic [W-1:0] act;
        string        nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {ld, err, full, empty, depth, addr};
                n_checks++;
                if (act === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got ld=%b err=%b full=%b empty=%b depth=%0d addr=%h, expected ld=%b err=%b full=%b empty=%b depth=%0d addr=%h",
                             nm, act[W-1], act[W-2], act[W-3], act[W-4], act[AW+SPW-1:AW], act[AW-1:0],
                             e[W-1], e[W-2], e[W-3], e[W-4], e[AW+SPW-1:AW], e[AW-1:0]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [AW-1:0] p;
        logic [AW-1:0] t;

        // Reset then idle.
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, mk(0, 0, 0, 1, 0, 16'h0000), "reset");
        for (int i = 0; i < 4; i++) idle(mk(0, 0, 0, 1, 0, 16'h0000), "idle_after_reset");

        // Single call / ret.
        drive(0, 1, 0, 16'h0010, 16'h0200, mk(1, 0, 0, 0, 1, 16'h0200), "call_single");
        drive(0, 0, 1, 16'h0000, 16'h0000, mk(1, 0, 0, 1, 0, 16'h0011), "ret_single");
        idle(mk(0, 0, 0, 1, 0, 16'h0011), "idle_addr_hold");

        // Nested calls, back-to-back.
        drive(0, 1, 0, 16'h0001, 16'h1000, mk(1, 0, 0, 0, 1, 16'h1000), "nest_call1");
        drive(0, 1, 0, 16'h0101, 16'h1100, mk(1, 0, 0, 0, 2, 16'h1100), "nest_call2");
        drive(0, 1, 0, 16'h0201, 16'h1200, mk(1, 0, 0, 0, 3, 16'h1200), "nest_call3");
        drive(0, 0, 1, 16'h0000, 16'h0000, mk(1, 0, 0, 0, 2, 16'h0202), "nest_ret1");
        drive(0, 0, 1, 16'h0000, 16'h0000, mk(1, 0, 0, 0, 1, 16'h0102), "nest_ret2");
        drive(0, 0, 1, 16'h0000, 16'h0000, mk(1, 0, 0, 1, 0, 16'h0002), "nest_ret3");

        // Return-address wrap-around.
        drive(0, 1, 0, 16'hffff, 16'h0300, mk(1, 0, 0, 0, 1, 16'h0300), "wrap_call");
        drive(0, 0, 1, 16'h0000, 16'h0000, mk(1, 0, 0, 1, 0, 16'h0000), "wrap_ret");

        // Fill the stack.
        for (int i = 0; i < DEPTH; i++) begin
            p = 16'h4000 + 16'(i * 16);
            t = 16'h8000 + 16'(i);
            drive(0, 1, 0, p, t,
                  mk(1, 0, (i == DEPTH - 1), 0, 5'(i + 1), t), "fill_call");
        end
        // Overflow: rejected, err rises, addr holds.
        drive(0, 1, 0, 16'h1234, 16'h5555, mk(0, 1, 1, 0, 16, 16'h800f), "overflow_call");
        // Drain: every return address intact, LIFO order.
        for (int j = 0; j < DEPTH; j++) begin
            p = 16'h4000 + 16'((DEPTH - 1 - j) * 16) + 16'h0001;
            drive(0, 0, 1, 16'h0000, 16'h0000,
                  mk(1, 1, 0, (j == DEPTH - 1), 5'(DEPTH - 1 - j), p), "drain_ret");
        end
        // Underflow.
        drive(0, 0, 1, 16'h0000, 16'h0000, mk(0, 1, 0, 1, 0, 16'h4001), "underflow_ret");

        // Stack still works after a fault; then call+ret together.
        drive(0, 1, 0, 16'h0020, 16'h0400, mk(1, 1, 0, 0, 1, 16'h0400), "call_after_err");
        drive(0, 1, 1, 16'h0777, 16'h0888, mk(0, 1, 0, 0, 1, 16'h0400), "call_and_ret");

        // Reset wins over a simultaneous call.
        drive(1, 1, 0, 16'h0050, 16'h0600, mk(0, 0, 0, 1, 0, 16'h0000), "rst_with_call");
        drive(0, 1, 0, 16'h0030, 16'h0500, mk(1, 0, 0, 0, 1, 16'h0500), "call_post_rst");
        drive(0, 0, 1, 16'h0000, 16'h0000, mk(1, 0, 0, 1, 0, 16'h0031), "ret_post_rst");
        idle(mk(0, 0, 0, 1, 0, 16'h0031), "final_idle");

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_call_stack

// File: doc/call_stack.md
# call_stack

Hardware return-address stack for the 16-bit CPU: captures return addresses on `call` and drives the program counter's `addr`/`ld` load interface on both `call` (jump to target) and `ret` (jump back). It is the producer side of the PC load port: `addr` and `ld` wire straight to `pc.addr` and `pc.ld`. It sits between the instruction decoder, which raises `call`/`ret`, and `pc`.

## Interface

Parameters:
- `DEPTH`, 16: number of return-address entries; a power of two, ≥ 2.
- `AW`, 16: address width; matches the `pc` width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `call`  in  1  decoder request: push the return address and jump to `tgt`.
- `ret`  in  1  decoder request: pop and jump to the popped address.
- `pc_in`  in  AW  current `pc.out`, the address of the call instruction.
- `tgt`  in  AW  call target address.
- `addr`  out  AW  load address to `pc.addr`; registered.
- `ld`  out  1  load strobe to `pc.ld`; registered, one-cycle pulse.
- `depth`  out  $clog2(DEPTH)+1  current number of valid entries.
- `empty`  out  1  `depth == 0`.
- `full`  out  1  `depth == DEPTH`.
- `err`  out  1  sticky fault flag; cleared only by `rst`.

## Operation

- Storage is a `DEPTH`×`AW` array plus a stack pointer `sp`, which equals `depth`. `sp` points at the next free slot.
- **Accepted call** (`call & ~ret & ~full`):
  - `mem[sp] <= pc_in + 1`, computed modulo 2^AW, so `0xffff` pushes `0x0000`.
  - `sp <= sp + 1`, `addr <= tgt`, `ld <= 1`.
- **Accepted ret** (`ret & ~call & ~empty`):
  - `sp <= sp - 1`, `addr <= mem[sp-1]`, `ld <= 1`.
- **Overflow** (`call & ~ret & full`): no push, `sp` unchanged, `ld <= 0`, `addr` holds, `err <= 1`.
- **Underflow** (`ret & ~call & empty`): `sp` unchanged, `ld <= 0`, `addr` holds, `err <= 1`.
- **Both `call` and `ret` high**: illegal. No stack change, `ld <= 0`, `err <= 1`.
- **Idle** (neither request high): `ld <= 0`, `addr` holds its last value, `sp` unchanged.
- `err` does not block later operations; the stack keeps working after a fault.
- Entry contents are not reset. Only `sp` and the outputs are.

## Timing

- Reset values: `addr = 0`, `ld = 0`, `depth = 0`, `empty = 1`, `full = 0`, `err = 0`.
- A request sampled at edge N produces `ld = 1` and a valid `addr` during cycle N→N+1. `pc` loads on that pulse, so latency from request to `ld` is 1 cycle.
- `ld` is never high for two consecutive cycles unless requests are accepted on consecutive edges. Back-to-back call/ret on successive cycles is legal, and each is evaluated against the `sp` updated by the previous edge.
- `depth`, `empty` and `full` are registered from `sp` and reflect the operation accepted at the previous edge.
- A push to the last free slot makes `full = 1` at the next cycle. A pop of the last entry makes `empty = 1` at the next cycle.
- `rst` asserted mid-sequence wins over any `call`/`ret` on the same edge. All outputs return to their reset values at that edge, and a pending `ld` pulse is cancelled.
- Combinational paths from inputs to outputs: none.

## Structure

- Shared package `cpu_pkg`: the `AW` width constant (16) and a `word_t` address typedef reused by `pc` and the decoder.
- One sub-module, `call_stack_mem`: a `DEPTH`×`AW` register file with synchronous write (`we`, `waddr`, `wdata`) and asynchronous read (`raddr`, `rdata`).
- `call_stack` itself holds `sp`, the request decode, the output registers and `err`.

## Test plan

- Reset then idle 4 cycles → `addr = 0x0000`, `ld = 0`, `empty = 1`, `depth = 0`, `err = 0` throughout.
- `pc_in = 0x0010`, `tgt = 0x0200`, pulse `call` → next cycle `ld = 1`, `addr = 0x0200`, `depth = 1`. Then pulse `ret` → `ld = 1`, `addr = 0x0011`, `depth = 0`, `empty = 1`.
- Nested calls from `0x0001`, `0x0101`, `0x0201`, then 3 rets → rets yield `addr = 0x0202`, `0x0102`, `0x0002` in that order.
- Wrap-around: `pc_in = 0xffff`, `call`, then `ret` → `addr = 0x0000` after the ret.
- Fill `DEPTH` calls → `full = 1`. One more call → `ld` stays 0, `depth` stays 16, `err = 1`. Then 16 rets return all addresses intact, and a 17th ret leaves `depth = 0` with `err` still 1.
- `call` and `ret` high together → `ld = 0`, `depth` unchanged, `err = 1`. Assert `rst` on the same edge as a `call` → `ld = 0`, `depth = 0`, `err = 0` next cycle.
